// File: rtl/mdu32_pkg.sv
// Shared definitions for the MIPS multiply/divide unit:
// funct codes, FSM state encoding and an operand-magnitude helper.
package mdu32_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude for signed ops; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: compare the shifted partial remainder
// against the divisor, subtract when it fits, and emit the quotient bit.
module mdu_div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [31:0] diff;

  // When the divisor fits, the true difference is below the divisor, so the
  // low 32 bits of the subtraction are exact.
  assign q_bit   = (rem_in >= {1'b0, divisor});
  assign diff    = rem_in[31:0] - divisor;
  assign rem_out = q_bit ? diff : rem_in[31:0];

endmodule

// File: rtl/mdu32.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO pair, with a
// registered busy/done handshake so the controller can stall the PC.
module mdu32
  import mdu32_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  input  logic [5:0]  Function_opcode,
  input  logic        Mdu_start,
  output logic        Mdu_busy,
  output logic        Mdu_done,
  output logic [31:0] Mdu_result
);

  localparam int CW = $clog2(ITER);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo;
  logic [31:0]   opnd;       // multiplicand for mult, divisor for div
  logic [63:0]   acc;        // {partial, multiplier} or {remainder, dividend/quotient}
  logic          op_div, neg_q, neg_r, div_zero;

  logic          accept, is_muldiv, signed_op;
  logic [31:0]   rs_mag, rt_mag;
  logic [32:0]   mul_sum;
  logic [31:0]   div_rem;
  logic          div_q;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  assign accept    = Mdu_start && (state == IDLE);
  assign is_muldiv = Function_opcode inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  assign signed_op = (Function_opcode == FUNCT_MULT) || (Function_opcode == FUNCT_DIV);
  assign rs_mag    = magnitude(Read_data_1, signed_op);
  assign rt_mag    = magnitude(Read_data_2, signed_op);

  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

  mdu_div_step u_div_step (
    .rem_in  ({acc[63:32], acc[31]}),
    .divisor (opnd),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // A zero divisor leaves quotient all-ones and the remainder equal to |rs|;
  // re-applying the remainder sign hands back rs unchanged.
  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quo_fix  = (neg_q && !div_zero) ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  assign Mdu_result = (Function_opcode == FUNCT_MFHI) ? hi : lo;

  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_muldiv) state_nx = BUSY;
      BUSY:    if (cnt == CW'(ITER - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      Mdu_busy <= 1'b0;
      Mdu_done <= 1'b0;
    end else begin
      state    <= state_nx;
      Mdu_busy <= (state_nx != IDLE);
      Mdu_done <= (state == FIX);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (Function_opcode == FUNCT_MTHI) hi <= Read_data_1;
          if (Function_opcode == FUNCT_MTLO) lo <= Read_data_1;
          if (is_muldiv) begin
            cnt      <= '0;
            op_div   <= Function_opcode[1];
            neg_q    <= signed_op & (Read_data_1[31] ^ Read_data_2[31]);
            neg_r    <= signed_op & Read_data_1[31];
            div_zero <= (Read_data_2 == 32'd0);
            if (Function_opcode[1]) begin
              opnd <= rt_mag;
              acc  <= {32'd0, rs_mag};
            end else begin
              opnd <= rs_mag;
              acc  <= {32'd0, rt_mag};
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          acc <= op_div ? {div_rem, acc[30:0], div_q} : {mul_sum, acc[31:1]};
        end
        FIX: begin
          if (op_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu32.sv
// Scoreboard bench for mdu32: the driver queues expected HI/LO reads from an
// arithmetic reference model; a monitor compares whenever the DUT presents data.
module tb_mdu32;
  import mdu32_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Read_data_1, Read_data_2;
  logic [5:0]  Function_opcode;
  logic        Mdu_start;
  logic        Mdu_busy, Mdu_done;
  logic [31:0] Mdu_result;

  mdu32 #(.ITER(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .Read_data_1     (Read_data_1),
    .Read_data_2     (Read_data_2),
    .Function_opcode (Function_opcode),
    .Mdu_start       (Mdu_start),
    .Mdu_busy        (Mdu_busy),
    .Mdu_done        (Mdu_done),
    .Mdu_result      (Mdu_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        probe = 1'b0;
  logic [31:0] hi_m = '0, lo_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", name, act, want);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          a, b;
    hi = '0;
    lo = '0;
    case (f)
      FUNCT_MULT: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        {hi, lo} = 64'(sp);
      end
      FUNCT_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        {hi, lo} = up;
      end
      FUNCT_DIV: begin
        if (rt == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = rs;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          a  = rs;
          b  = rt;
          lo = a / b;
          hi = a % b;
        end
      end
      default: begin
        if (rt == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = rs;
        end else begin
          lo = rs / rt;
          hi = rs % rt;
        end
      end
    endcase
  endfunction

  // Monitor: the DUT presents LO on a done pulse, or HI/LO on an mf* read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (Mdu_done || probe) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %08h, want no output", Mdu_result);
        end else begin
          e = exp_q.pop_front();
          check(e.name, Mdu_result, e.val);
        end
      end
    end
  end

  task automatic read_hilo();
    @(negedge clock);
    Function_opcode = FUNCT_MFHI;
    Mdu_start = 1'b1;
    probe = 1'b1;
    exp_q.push_back('{"mfhi", hi_m});
    @(negedge clock);
    check("mf_busy", {31'd0, Mdu_busy}, 32'd0);
    Function_opcode = FUNCT_MFLO;
    exp_q.push_back('{"mflo", lo_m});
    @(negedge clock);
    Mdu_start = 1'b0;
    probe = 1'b0;
  endtask

  task automatic move(input logic [5:0] f, input logic [31:0] v);
    @(negedge clock);
    Function_opcode = f;
    Read_data_1 = v;
    Mdu_start = 1'b1;
    @(negedge clock);
    Mdu_start = 1'b0;
    check("mt_busy", {31'd0, Mdu_busy}, 32'd0);
    if (f == FUNCT_MTHI) hi_m = v;
    else lo_m = v;
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, input bit chaos);
    logic [31:0] hi_e, lo_e;
    int          cyc;
    ref_model(f, rs, rt, hi_e, lo_e);
    Function_opcode = f;
    Read_data_1 = rs;
    Read_data_2 = rt;
    Mdu_start = 1'b1;
    cyc = 0;
    @(negedge clock);
    while (Mdu_busy && cyc < 60) begin
      cyc++;
      Mdu_start = 1'b0;
      probe = 1'b0;
      Function_opcode = f;
      if (chaos) begin
        Read_data_1 = $urandom;
        Read_data_2 = $urandom;
        if (cyc == 3) begin
          Function_opcode = FUNCT_MFHI;
          Mdu_start = 1'b1;
          probe = 1'b1;
          exp_q.push_back('{"busy_mfhi", hi_m});
        end
        if (cyc == 5) begin
          Function_opcode = FUNCT_MTHI;
          Mdu_start = 1'b1;
        end
        if (cyc == 7) begin
          Function_opcode = FUNCT_MULT;
          Mdu_start = 1'b1;
        end
      end
      @(negedge clock);
    end
    Mdu_start = 1'b0;
    probe = 1'b0;
    Function_opcode = f;
    check("busy_cycles", 32'(cyc), 32'd33);
    check("done_pulse", {31'd0, Mdu_done}, 32'd1);
    hi_m = hi_e;
    lo_m = lo_e;
    exp_q.push_back('{"done_lo", lo_e});
  endtask

  task automatic run_abort(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, input int at);
    logic done_seen;
    Function_opcode = f;
    Read_data_1 = rs;
    Read_data_2 = rt;
    Mdu_start = 1'b1;
    @(negedge clock);
    Mdu_start = 1'b0;
    repeat (at) @(negedge clock);
    check("abort_pre_busy", {31'd0, Mdu_busy}, 32'd1);
    reset = 1'b1;
    Mdu_start = 1'b1;
    Function_opcode = FUNCT_MULT;
    @(negedge clock);
    reset = 1'b0;
    Mdu_start = 1'b0;
    Function_opcode = f;
    check("abort_busy", {31'd0, Mdu_busy}, 32'd0);
    check("abort_done", {31'd0, Mdu_done}, 32'd0);
    hi_m = '0;
    lo_m = '0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (Mdu_done || Mdu_busy) done_seen = 1'b1;
    end
    check("abort_no_activity", {31'd0, done_seen}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [5:0] ops[4];
    ops[0] = FUNCT_MULT;
    ops[1] = FUNCT_MULTU;
    ops[2] = FUNCT_DIV;
    ops[3] = FUNCT_DIVU;

    // Reset held alongside an mthi start: reset must win.
    reset = 1'b1;
    Mdu_start = 1'b1;
    Function_opcode = FUNCT_MTHI;
    Read_data_1 = 32'hDEAD_BEEF;
    Read_data_2 = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    Mdu_start = 1'b0;
    check("rst_busy", {31'd0, Mdu_busy}, 32'd0);
    check("rst_done", {31'd0, Mdu_done}, 32'd0);
    read_hilo();

    // Directed cases.
    run_op(FUNCT_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    read_hilo();
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    read_hilo();
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    read_hilo();
    run_op(FUNCT_DIVU, 32'h0000_1234, 32'd0, 1'b1);
    read_hilo();
    move(FUNCT_MTHI, 32'hCAFE_BABE);
    move(FUNCT_MTLO, 32'd5);
    read_hilo();
    run_abort(FUNCT_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 9);
    read_hilo();

    // Randomized mix, with back-to-back issue whenever the read is skipped.
    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(0, 3)], pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) read_hilo();
    end
    read_hilo();

    @(negedge clock);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_outputs: got %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
